// File: rtl/vp_stream_ctrl.sv
// vp_stream_ctrl
// Output stream selector control for the video processing top.
//   - Synchronizes and debounces the board switches.
//   - Applies a new selection only on a vsync rising edge, or at once when
//     there is no input video.
//   - Blanks the output for BLANK_FRAMES frames after each switch and
//     pulses stage_rst to the centroid stage.
//   - Counts frames and flags loss of video.
//
// Ports:
//   clk        pixel clock, the only clock
//   rst        asynchronous active-high reset
//   sw[2:0]    raw board switches, asynchronous to clk
//   vsync      input stream v_sync, synchronous to clk
//   sel[2:0]   stream select for the output muxes
//   blank      1 = output pixel forced to black
//   stage_rst  one-cycle reset pulse to the centroid stage per applied switch
//   frame_cnt  count of vsync rising edges, wraps
//   no_video   1 = no vsync rise for TIMEOUT_CYCLES clocks
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | idle, sel settled, watching for a valid new request
// PENDING | request seen, waiting for a frame boundary (or no video)
// BLANK   | switch applied, output blanked until blank_cnt frames pass

module vp_stream_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLANK_FRAMES    = 1,
  parameter int NUM_SRC         = 5,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sw,
  input  logic        vsync,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        stage_rst,
  output logic [15:0] frame_cnt,
  output logic        no_video
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_PRE    = DEB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BLANK_INIT = 4'(BLANK_FRAMES);
  localparam logic [3:0]       NUM_SRC_L  = 4'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLANK   = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       sw_meta;
  logic [2:0]       sw_sync;
  logic [2:0]       cand;
  logic [DEB_W-1:0] deb_cnt;
  logic [2:0]       sw_stable;
  logic             vsync_d;
  logic [WD_W-1:0]  wd_cnt;
  logic [3:0]       blank_cnt;
  logic             vs_rise;
  logic             req_valid;

  assign vs_rise   = vsync & ~vsync_d;
  assign req_valid = ({1'b0, sw_stable} < NUM_SRC_L) && (sw_stable != sel);

  // Switch synchronizer and debounce. sw_stable is written on the same edge
  // the counter reaches its last value, so a clean change lands
  // 2 + DEBOUNCE_CYCLES edges after it is first sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      cand      <= '0;
      deb_cnt   <= '0;
      sw_stable <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (sw_sync != cand) begin
        cand    <= sw_sync;
        deb_cnt <= '0;
        if (DEBOUNCE_CYCLES == 1) begin
          sw_stable <= sw_sync;
        end
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + 1'b1;
        if (deb_cnt == DEB_PRE) begin
          sw_stable <= cand;
        end
      end
    end
  end

  // Frame counter and no-video watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      frame_cnt <= '0;
      wd_cnt    <= '0;
      no_video  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
        wd_cnt    <= '0;
        no_video  <= 1'b0;
      end else if (wd_cnt == WD_LAST) begin
        no_video <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  // Selection FSM. Requests arriving while blanked are only looked at again
  // once back in RUN, so a switch never chains directly out of BLANK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      sel       <= '0;
      blank     <= 1'b0;
      stage_rst <= 1'b0;
      blank_cnt <= '0;
    end else begin
      stage_rst <= 1'b0;
      case (state)
        ST_RUN: begin
          if (req_valid) begin
            state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (!req_valid) begin
            state <= ST_RUN;
          end else if (vs_rise || no_video) begin
            sel       <= sw_stable;
            stage_rst <= 1'b1;
            if (BLANK_FRAMES > 0) begin
              blank     <= 1'b1;
              blank_cnt <= BLANK_INIT;
              state     <= ST_BLANK;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_BLANK: begin
          // The rise that applied the switch was consumed in PENDING,
          // so only later rises are counted here.
          if (vs_rise) begin
            blank_cnt <= blank_cnt - 4'd1;
            if (blank_cnt == 4'd1) begin
              blank <= 1'b0;
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vp_stream_ctrl.sv
module tb_vp_stream_ctrl;

  localparam int DEB  = 4;
  localparam int BLK  = 1;
  localparam int NSRC = 5;
  localparam int TMO  = 100;

  logic        clk;
  logic        rst;
  logic [2:0]  sw;
  logic        vsync;
  logic [2:0]  sel;
  logic        blank;
  logic        stage_rst;
  logic [15:0] frame_cnt;
  logic        no_video;

  int   n_total = 0;
  int   n_bad   = 0;
  int   n_stage = 0;
  logic vs_en   = 1'b0;
  int   vs_ph   = 0;

  vp_stream_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLANK_FRAMES   (BLK),
    .NUM_SRC        (NSRC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .vsync    (vsync),
    .sel      (sel),
    .blank    (blank),
    .stage_rst(stage_rst),
    .frame_cnt(frame_cnt),
    .no_video (no_video)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // vsync source: 64-cycle period, high for the first 8 phases.
  initial begin
    vsync = 1'b0;
    forever begin
      @(negedge clk);
      if (vs_en) begin
        vsync = (vs_ph < 8);
        vs_ph = (vs_ph == 63) ? 0 : vs_ph + 1;
      end else begin
        vsync = 1'b0;
      end
    end
  end

  // Reference model, evaluated per clock edge from the behavioural rules:
  // a value is accepted once it has been seen DEB times in a row after the
  // two-stage sync; switches wait for a frame boundary or lost video; a
  // switch starts BLK frames of blanking; no_video means TMO edges since
  // the last rise.
  logic [2:0]  m_sel, m_stable;
  logic        m_wait, m_stage, m_nov, m_prev_vs, m_rise, m_valid, m_eq;
  int          m_blank_left;
  logic [15:0] m_frames;
  longint      m_edge, m_last_rise;
  logic [2:0]  hist [DEB+2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel = 3'd0; m_stable = 3'd0; m_wait = 1'b0; m_stage = 1'b0;
      m_nov = 1'b0; m_prev_vs = 1'b0; m_blank_left = 0; m_frames = 16'd0;
      m_edge = 0; m_last_rise = 0;
      for (int i = 0; i < DEB + 2; i++) hist[i] = 3'd0;
    end else begin
      m_rise  = vsync && !m_prev_vs;
      m_valid = (int'(m_stable) < NSRC) && (m_stable != m_sel);
      m_stage = 1'b0;
      if (m_blank_left > 0) begin
        if (m_rise) m_blank_left = m_blank_left - 1;
      end else if (!m_wait) begin
        m_wait = m_valid;
      end else if (!m_valid) begin
        m_wait = 1'b0;
      end else if (m_rise || m_nov) begin
        m_sel        = m_stable;
        m_stage      = 1'b1;
        m_wait       = 1'b0;
        m_blank_left = BLK;
      end
      m_edge = m_edge + 1;
      if (m_rise) begin
        m_frames    = m_frames + 16'd1;
        m_last_rise = m_edge;
      end
      m_nov = (m_edge - m_last_rise) >= TMO;
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw;
      m_eq = 1'b1;
      for (int i = 3; i <= DEB + 1; i++) if (hist[i] !== hist[2]) m_eq = 1'b0;
      if (m_eq) m_stable = hist[2];
      m_prev_vs = vsync;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cycle", 32'({sel, blank, stage_rst, frame_cnt, no_video}),
          32'({m_sel, (m_blank_left > 0), m_stage, m_frames, m_nov}));
      if (stage_rst === 1'b1) n_stage++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_phase(input int p);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (vs_ph != p && k < 200);
    if (k >= 200) chk("phase_timeout", 32'(vs_ph), 32'(p));
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd0);
    chk({tag, "_stage"}, 32'(stage_rst), 32'd0);
    chk({tag, "_frames"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_nov"}, 32'(no_video), 32'd0);
  endtask

  initial begin
    int ns0;
    int k;
    rst = 1'b1;
    sw  = 3'd0;
    cyc(4);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst   = 1'b0;
    vs_en = 1'b1;

    // idle, three frames
    to_phase(32);
    cyc(128);
    chk("idle_frames", 32'(frame_cnt), 32'd3);
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_nov", 32'(no_video), 32'd0);
    chk("idle_stage", 32'(n_stage), 32'd0);

    // mid-frame switch to 2
    sw = 3'd2;
    cyc(20);
    chk("hold_sel", 32'(sel), 32'd0);
    to_phase(4);
    chk("apply_sel", 32'(sel), 32'd2);
    chk("apply_blank", 32'(blank), 32'd1);
    chk("apply_stage", 32'(n_stage), 32'd1);
    to_phase(4);
    chk("blank_release", 32'(blank), 32'd0);
    chk("one_pulse", 32'(n_stage), 32'd1);

    // 3-cycle glitch is rejected
    sw = 3'd3;
    cyc(3);
    sw = 3'd2;
    to_phase(40);
    to_phase(40);
    chk("glitch_sel", 32'(sel), 32'd2);
    chk("glitch_stage", 32'(n_stage), 32'd1);

    // out-of-range code ignored
    sw = 3'd6;
    to_phase(40);
    to_phase(40);
    chk("invalid_sel", 32'(sel), 32'd2);
    chk("invalid_stage", 32'(n_stage), 32'd1);

    // request during blanking is deferred
    sw = 3'd1;
    to_phase(2);
    chk("sw1_sel", 32'(sel), 32'd1);
    chk("sw1_blank", 32'(blank), 32'd1);
    sw = 3'd4;
    to_phase(2);
    chk("defer_sel", 32'(sel), 32'd1);
    chk("defer_blank", 32'(blank), 32'd0);
    to_phase(2);
    chk("deferred_sel", 32'(sel), 32'd4);
    chk("deferred_blank", 32'(blank), 32'd1);
    chk("deferred_stage", 32'(n_stage), 32'd3);
    to_phase(2);
    chk("deferred_unblank", 32'(blank), 32'd0);

    // watchdog and switch without video
    vs_en = 1'b0;
    cyc(105);
    chk("nov_set", 32'(no_video), 32'd1);
    sw = 3'd0;
    cyc(12);
    chk("nov_sel", 32'(sel), 32'd0);
    chk("nov_stage", 32'(n_stage), 32'd4);
    chk("nov_blank", 32'(blank), 32'd1);
    chk("nov_still", 32'(no_video), 32'd1);
    vs_en = 1'b1;
    to_phase(60);
    to_phase(4);
    chk("nov_clear", 32'(no_video), 32'd0);
    chk("nov_unblank", 32'(blank), 32'd0);

    // frame counter wrap
    cyc(10);
    force dut.frame_cnt = 16'hFFFE;
    m_frames = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    to_phase(4);
    chk("wrap_ffff", 32'(frame_cnt), 32'h0000FFFF);
    to_phase(4);
    chk("wrap_zero", 32'(frame_cnt), 32'd0);

    // reset while a switch is pending
    to_phase(20);
    sw = 3'd3;
    cyc(10);
    chk("pending_sel", 32'(sel), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("rst_pending");
    sw = 3'd0;
    cyc(3);
    rst = 1'b0;
    ns0 = n_stage;
    to_phase(40);
    to_phase(40);
    chk("post_rst_sel", 32'(sel), 32'd0);
    chk("post_rst_stage", 32'(n_stage), 32'(ns0));

    // reset while blanking
    sw = 3'd2;
    k = 0;
    while (blank !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("blank_seen", 32'(blank), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("rst_blank");
    sw = 3'd0;
    cyc(3);
    rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      sw    = 3'($urandom_range(0, 7));
      vs_en = ($urandom_range(0, 7) != 0);
      cyc($urandom_range(1, 150));
    end
    vs_en = 1'b1;
    cyc(200);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
